// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative multiply/divide unit holding the HI/LO register pair. It sits in
// the execute stage beside the single-cycle ALU. It runs mult/multu/div/divu
// over WIDTH iteration cycles plus one fix-up cycle. It serves mfhi/mflo/mthi/mtlo
// directly from the HI/LO registers.
//
// Ports:
//   clk              - system clock, rising edge
//   reset            - asynchronous, active-high reset
//   start            - execute-stage instruction valid
//   CONTROL_ALU_BITS - 6-bit operation code (R-type funct) from ALU control
//   operand_a        - rs value: multiplicand / dividend / mthi-mtlo source
//   operand_b        - rt value: multiplier / divisor
//   hi, lo           - HI and LO registers
//   result           - hi for mfhi, lo for mflo, otherwise 0 (combinational)
//   busy             - a multi-cycle operation is in progress
//   done             - one-cycle pulse when a mult/div writes HI/LO
//   stall            - a handled instruction was presented while busy
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       CONTROL_ALU_BITS,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_m;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic               op_div;

  logic               is_mul;
  logic               is_div;
  logic               handled;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Decode the operation code and derive the stall request. A handled code
  // presented while busy is refused and the pipeline must hold it.
  always_comb begin
    is_mul  = (CONTROL_ALU_BITS == OP_MULT) || (CONTROL_ALU_BITS == OP_MULTU);
    is_div  = (CONTROL_ALU_BITS == OP_DIV)  || (CONTROL_ALU_BITS == OP_DIVU);
    handled = is_mul || is_div ||
              (CONTROL_ALU_BITS == OP_MFHI) || (CONTROL_ALU_BITS == OP_MFLO) ||
              (CONTROL_ALU_BITS == OP_MTHI) || (CONTROL_ALU_BITS == OP_MTLO);
    stall   = start & busy & handled;
  end

  // mfhi/mflo read straight from the registers, so the value is available in
  // the same cycle the instruction is presented.
  always_comb begin
    result = '0;
    if (CONTROL_ALU_BITS == OP_MFHI)
      result = hi;
    else if (CONTROL_ALU_BITS == OP_MFLO)
      result = lo;
  end

  // The core works on magnitudes only. The signed opcodes have a zero LSB.
  // The negation of the most negative value wraps to itself, and that is
  // still the correct unsigned magnitude.
  always_comb begin
    signed_op = ~CONTROL_ALU_BITS[0];
    a_neg     = signed_op & operand_a[WIDTH-1];
    b_neg     = signed_op & operand_b[WIDTH-1];
    a_mag     = a_neg ? -operand_a : operand_a;
    b_mag     = b_neg ? -operand_b : operand_b;
  end

  // One iteration step for each algorithm, plus the final sign fix-up.
  // Multiply uses a right-shifting accumulator. The upper half collects the
  // partial sum. The lower half starts as the multiplier and is consumed one
  // bit per cycle.
  // Divide uses the restoring scheme. The upper half is the partial remainder.
  // The lower half starts as the dividend and fills with quotient bits.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_m} : '0);
    div_part = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = div_part >= {1'b0, mag_m};
    div_diff = div_part[WIDTH-1:0] - mag_m;
    prod_fix = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Main sequencer. IDLE accepts new work. MUL/DIV each run WIDTH iterations.
  // FIX applies the signs and is the only place HI/LO change for mult/div.
  // A divide by zero leaves the remainder equal to the dividend magnitude,
  // so after the sign fix-up HI equals the sampled operand_a. Only LO needs
  // to be forced to all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mag_m    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      op_div   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              mag_m  <= a_mag;
              acc    <= {{WIDTH{1'b0}}, b_mag};
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= 1'b0;
              op_div <= 1'b0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MUL;
            end else if (is_div) begin
              mag_m    <= b_mag;
              acc      <= {{WIDTH{1'b0}}, a_mag};
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= (operand_b == '0);
              op_div   <= 1'b1;
              cnt      <= '0;
              busy     <= 1'b1;
              state    <= DIV;
            end else if (CONTROL_ALU_BITS == OP_MTHI) begin
              hi <= operand_a;
            end else if (CONTROL_ALU_BITS == OP_MTLO) begin
              lo <= operand_a;
            end
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= FIX;
        end
        DIV: begin
          if (div_ge)
            acc <= {div_diff, acc[WIDTH-2:0], 1'b1};
          else
            acc <= {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          if (op_div) begin
            lo <= div_zero ? {WIDTH{1'b1}} : quot_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Directed bench for mul_div_unit. Each mult/div pushes its hand-computed
// {hi,lo} into a queue when it is issued. A monitor pops the queue and
// compares on every done pulse. Register, stall and reset behaviour are
// checked inline by the stimulus process.
module tb_mul_div_unit;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  code = 6'b0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        stall;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] expQueue[$];
  logic [63:0] sbExp;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .CONTROL_ALU_BITS(code),
    .operand_a(opA),
    .operand_b(opB),
    .hi(hi),
    .lo(lo),
    .result(result),
    .busy(busy),
    .done(done),
    .stall(stall)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Compare one value against its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present one instruction for a single rising edge. This task is entered and
  // left at a falling edge. The expectation is queued only for mult/div ops
  // that are meant to complete.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit queueIt,
                               input logic [63:0] expHiLo);
    if (queueIt)
      expQueue.push_back(expHiLo);
    start = 1'b1;
    code  = op;
    opA   = a;
    opB   = b;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  // Count the falling edges on which busy is high, then confirm that done is
  // pulsing. The wait is bounded so that a stuck unit cannot hang the run.
  task automatic waitDone(input string name, input int expCycles);
    int cycles;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got busy still high expected done within 200 cycles", name);
    end else begin
      if (expCycles > 0)
        checkOutput({name, "_busy_cycles"}, cycles, expCycles);
      checkOutput({name, "_done"}, {31'b0, done}, 32'd1);
    end
  endtask

  // Scoreboard monitor. Every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (expQueue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        sbExp = expQueue.pop_front();
        checkOutput("sb_hi", hi, sbExp[63:32]);
        checkOutput("sb_lo", lo, sbExp[31:0]);
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    logic [5:0] busyCodes[6];
    bit         busyStall[6];
    busyCodes = '{OP_MFLO, OP_MULT, OP_ADD, OP_MTHI, OP_DIVU, OP_MFHI};
    busyStall = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    #1;
    checkOutput("rst_hi", hi, 32'h0);
    checkOutput("rst_lo", lo, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] multu full-scale");
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001);
    waitDone("multu", 33);

    $display("[TB] mult -3 x 7 issued in the done cycle");
    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFEB);
    checkOutput("done_clears", {31'b0, done}, 32'd0);
    waitDone("mult", 33);
    start = 1'b1;
    code  = OP_MFLO;
    #1;
    checkOutput("mflo_result", result, 32'hFFFFFFEB);
    checkOutput("mflo_stall", {31'b0, stall}, 32'd0);
    code = OP_MFHI;
    #1;
    checkOutput("mfhi_result", result, 32'hFFFFFFFF);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);

    $display("[TB] divides");
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
    waitDone("div_neg", 33);
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
    waitDone("divu", 33);
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000);
    waitDone("div_intmin", 33);
    applyStimulus(OP_DIVU, 32'h12345678, 32'h0, 1'b1, 64'h12345678_FFFFFFFF);
    waitDone("divu_zero", 33);
    applyStimulus(OP_DIV, 32'hFFFFFFF0, 32'h0, 1'b1, 64'hFFFFFFF0_FFFFFFFF);
    waitDone("div_zero", 33);

    $display("[TB] requests while busy");
    applyStimulus(OP_MULT, 32'h00010000, 32'h00010000, 1'b1, 64'h00000001_00000000);
    for (int i = 0; i < 6; i++) begin
      start = 1'b1;
      code  = busyCodes[i];
      opA   = 32'd3;
      opB   = 32'd5;
      #1;
      checkOutput("busy_stall", {31'b0, stall}, {31'b0, busyStall[i]});
      checkOutput("busy_hi_hold", hi, 32'hFFFFFFF0);
      checkOutput("busy_lo_hold", lo, 32'hFFFFFFFF);
      @(negedge clk);
    end
    start = 1'b0;
    waitDone("mult_stalled", 0);
    applyStimulus(OP_MULT, 32'd3, 32'd5, 1'b1, {32'd0, 32'd15});
    waitDone("mult_represent", 33);
    start = 1'b1;
    code  = OP_MFLO;
    #1;
    checkOutput("mflo_represent", result, 32'd15);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);

    $display("[TB] reset during divide");
    applyStimulus(OP_DIV, 32'd1000, 32'd3, 1'b0, 64'h0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrst_hi", hi, 32'h0);
    checkOutput("midrst_lo", lo, 32'h0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(OP_MTHI, 32'hA5A5A5A5, 32'h0, 1'b0, 64'h0);
    checkOutput("mthi_hi", hi, 32'hA5A5A5A5);
    checkOutput("mthi_lo", lo, 32'h0);
    checkOutput("mthi_busy", {31'b0, busy}, 32'd0);
    checkOutput("mthi_done", {31'b0, done}, 32'd0);
    applyStimulus(OP_MTLO, 32'h0BADF00D, 32'h0, 1'b0, 64'h0);
    checkOutput("mtlo_lo", lo, 32'h0BADF00D);
    checkOutput("mtlo_hi", hi, 32'hA5A5A5A5);
    repeat (3) @(negedge clk);

    checkOutput("sb_empty", expQueue.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with the HI/LO register pair. Sits directly downstream of the ALU control decoder and consumes its 6-bit CONTROL_ALU_BITS (R-type funct pass-through) in the execute stage, beside the single-cycle ALU.
- Executes mult/multu/div/divu over multiple cycles and serves mfhi/mflo/mthi/mtlo.
- Raises a stall request so the pipeline holds while a result is pending.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  execute-stage instruction valid, sampled on the rising edge of clk.
- CONTROL_ALU_BITS  input  6  operation code from ALU control.
- operand_a  input  WIDTH  rs value; multiplicand/dividend, or source for mthi/mtlo.
- operand_b  input  WIDTH  rt value; multiplier/divisor.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- result  output  WIDTH  mfhi: hi; mflo: lo; else 0. Combinational from the registers.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse when HI/LO are written by mult/div.
- stall  output  1  combinational; start & busy & code in {mult, multu, div, divu, mfhi, mflo, mthi, mtlo}.

Behaviour:
- Codes handled: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo. All other codes are ignored; the unit has no effect and stall=0.
- Reset (asynchronous, any time, including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0, internal accumulators=0. No partial result survives.
- States: IDLE, MUL, DIV, FIX.
- IDLE + start + mult/multu at edge N:
  - Latch magnitudes (signed ops take the two's-complement absolute value) and the result sign.
  - Go to MUL; busy=1 from N.
- IDLE + start + div/divu:
  - Same latch; go to DIV.
  - Quotient sign = sa^sb; remainder sign = sa.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit product accumulator. Counter runs 0..WIDTH-1; after WIDTH iteration edges (N+1..N+WIDTH) go to FIX.
- DIV: restoring division, one quotient bit per cycle, same counter and exit timing.
- FIX at edge N+WIDTH+1:
  - Apply sign correction.
  - Write hi/lo: mult gives {hi,lo}=product; div gives lo=quotient, hi=remainder.
  - done=1, busy=0, return to IDLE.
  - done clears at the following edge.
- Latency: operands sampled at N; result visible after edge N+WIDTH+1, i.e. N+33 for WIDTH=32.
- Divide by zero (operand_b=0, signed or unsigned): no trap. hi=operand_a as sampled, lo=all ones. Timing is identical to a normal divide.
- Signed INT_MIN / -1: lo=0x80000000, hi=0. No trap.
- mthi/mtlo with start in IDLE: hi (or lo) = operand_a at that edge. Single cycle, no done pulse.
- mfhi/mflo in IDLE: result is valid in the same cycle. No state change.
- start with any handled code while busy: the unit ignores the request (operands not sampled, HI/LO untouched) and asserts stall. The pipeline re-presents the instruction until busy falls.
- start in the cycle done=1: state is IDLE, so the request is accepted normally and mfhi/mflo see the new values.
- hi/lo hold their values throughout MUL/DIV; only the FIX edge updates them.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF: busy for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- mult -3 x 7 (0xFFFFFFFD, 0x00000007): hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then mflo gives result=0xFFFFFFEB in the same cycle.
- div -7 / 2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 100 / 7: lo=14, hi=2. div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu 0x12345678 / 0: after 33 cycles hi=0x12345678, lo=0xFFFFFFFF, done=1.
- mult in flight, then mflo and a second mult presented while busy: stall=1 each cycle, hi/lo unchanged until FIX, second op not started. Re-presented after done: accepted and correct.
- Assert reset at iteration 10 of a div: hi=lo=0, busy=0, done=0 immediately. A following mthi 0xA5A5A5A5 sets hi=0xA5A5A5A5 in one cycle with no done pulse.
